// File: rtl/ddr_rd_burst_sched_if.sv
// AXI4 read-address/read-data signals plus the FIFO write-side status
// seen by the DDR read burst scheduler.
interface ddr_rd_burst_sched_if #(
    parameter int ADDR_W  = 28,
    parameter int LEVEL_W = 10
);
    logic [ADDR_W-1:0]  araddr;
    logic [7:0]         arlen;
    logic               arvalid;
    logic               arready;
    logic               rvalid;
    logic               rlast;
    logic               rready;
    logic [LEVEL_W-1:0] fifo_water_level;
    logic               fifo_wr_full;
    logic               fifo_wr_en;

    // Scheduler side
    modport master (
        output araddr, arlen, arvalid, rready, fifo_wr_en,
        input  arready, rvalid, rlast, fifo_water_level, fifo_wr_full
    );

    // DDR controller / FIFO side
    modport slave (
        input  araddr, arlen, arvalid, rready, fifo_wr_en,
        output arready, rvalid, rlast, fifo_water_level, fifo_wr_full
    );
endinterface

// File: rtl/ddr_rd_burst_sched.sv
// ddr_rd_burst_sched: per-frame AXI4 INCR read burst issuer feeding the
// 256b read FIFO. A burst is only requested when its full length is
// guaranteed to fit in the FIFO, counting beats already requested but not
// yet written, so the FIFO can never overflow.
module ddr_rd_burst_sched #(
    parameter int ADDR_W     = 28,
    parameter int BEATS_W    = 20,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int LEVEL_W    = 10,
    parameter int BEAT_BYTES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [ADDR_W-1:0]  frame_base,
    input  logic [BEATS_W-1:0] frame_beats,
    output logic               busy,
    output logic               frame_done,
    ddr_rd_burst_sched_if.master bus
);
    localparam int BLEN_W = $clog2(BURST_LEN + 1);
    localparam int OUT_W  = LEVEL_W + 1;
    localparam int CHK_W  = ((LEVEL_W + 2) > (BLEN_W + 1)) ? (LEVEL_W + 2) : (BLEN_W + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BEATS_W-1:0] remaining_q, remaining_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               wr_en_dly_q, wr_en_dly_d;
    logic [7:0]         arlen_q, arlen_d;
    logic [7:0]         rbeat_q, rbeat_d;

    logic               wr_en;
    logic               ar_hs;
    logic               issue_ok;
    logic               rlast_exp;
    logic [BLEN_W-1:0]  blen;
    logic [OUT_W-1:0]   reserved;

    assign wr_en          = bus.rvalid & ~bus.fifo_wr_full;
    assign bus.rready     = ~bus.fifo_wr_full;
    assign bus.fifo_wr_en = wr_en;
    assign bus.arvalid    = (state_q == REQ);
    assign bus.araddr     = addr_q;
    assign bus.arlen      = arlen_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);
    assign ar_hs          = (state_q == REQ) & bus.arready;

    // Burst length and FIFO space check; wr_en_dly covers the cycle where the
    // water level has not yet caught up with a write already taken off R.
    always_comb begin
        if (remaining_q < BEATS_W'(BURST_LEN)) begin
            blen = remaining_q[BLEN_W-1:0];
        end else begin
            blen = BLEN_W'(BURST_LEN);
        end
        reserved = OUT_W'(bus.fifo_water_level) + outstanding_q + OUT_W'(wr_en_dly_q);
        issue_ok = (CHK_W'(reserved) + CHK_W'(blen)) <= CHK_W'(FIFO_DEPTH);
    end

    // Frame FSM: load frame, wait for space, hold AR until accepted, drain R.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        arlen_d     = arlen_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    addr_d      = frame_base;
                    remaining_d = frame_beats;
                    state_d     = (frame_beats == '0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (issue_ok) begin
                    arlen_d = 8'(blen - BLEN_W'(1));
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.arready) begin
                    addr_d      = addr_q + ADDR_W'(blen) * ADDR_W'(BEAT_BYTES);
                    remaining_d = remaining_q - BEATS_W'(blen);
                    state_d     = (remaining_q == BEATS_W'(blen)) ? DRAIN : CHECK;
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beats in flight on R, and the beat position inside the current R burst.
    // Only the last burst of a frame can be shorter than BURST_LEN, and its
    // final beat is the one that leaves a single beat outstanding with
    // nothing left to request.
    always_comb begin
        outstanding_d = outstanding_q + (ar_hs ? OUT_W'(blen) : '0) - OUT_W'(wr_en);
        wr_en_dly_d   = wr_en;
        rlast_exp     = (rbeat_q == 8'(BURST_LEN - 1)) ||
                        ((remaining_q == '0) && (outstanding_q == OUT_W'(1)));
        if (wr_en) begin
            rbeat_d = rlast_exp ? '0 : rbeat_q + 8'd1;
        end else begin
            rbeat_d = rbeat_q;
        end
    end

    // State and counter registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            wr_en_dly_q   <= 1'b0;
            arlen_q       <= '0;
            rbeat_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            wr_en_dly_q   <= wr_en_dly_d;
            arlen_q       <= arlen_d;
            rbeat_q       <= rbeat_d;
        end
    end

    // rlast never steers control; it must agree with the requested burst length.
    a_rlast: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> (bus.rlast == rlast_exp));

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// Testbench for ddr_rd_burst_sched: random AXI slave and FIFO model, with a
// scoreboard of expected AR bursts derived from frame base/length.
`timescale 1ns/1ps
module tb_ddr_rd_burst_sched;
    localparam int ADDR_W     = 28;
    localparam int BEATS_W    = 20;
    localparam int BURST_LEN  = 16;
    localparam int FIFO_DEPTH = 512;
    localparam int LEVEL_W    = 10;
    localparam int BEAT_BYTES = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame_start = 1'b0;
    logic [ADDR_W-1:0]  frame_base = '0;
    logic [BEATS_W-1:0] frame_beats = '0;
    logic               busy;
    logic               frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment model state
    int                fifo_cnt = 0;
    int                rq[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int                exp_len[$];
    int                ar_cnt = 0;
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                cur_beats = 0;
    bit                frame_active = 1'b0;
    int                ar_mode = 1;
    bit                rd_on = 1'b1;
    bit                lvl_ovr_en = 1'b0;
    int                lvl_ovr = 0;
    logic              arready_v = 1'b0;
    logic              rvalid_v = 1'b0;
    logic              rlast_v = 1'b0;
    bit                hs_ar, hs_r, rd, hold_v;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_len;
    int                ar_len_hs;

    always #5 clk = ~clk;

    ddr_rd_burst_sched_if #(.ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W)) bus ();

    assign bus.arready          = arready_v;
    assign bus.rvalid           = rvalid_v;
    assign bus.rlast            = rlast_v;
    assign bus.fifo_water_level = lvl_ovr_en ? LEVEL_W'(lvl_ovr) : LEVEL_W'(fifo_cnt);
    assign bus.fifo_wr_full     = (fifo_cnt >= FIFO_DEPTH);

    ddr_rd_burst_sched #(
        .ADDR_W(ADDR_W), .BEATS_W(BEATS_W), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W), .BEAT_BYTES(BEAT_BYTES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .frame_base(frame_base),
        .frame_beats(frame_beats),
        .busy(busy),
        .frame_done(frame_done),
        .bus(bus)
    );

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor / slave model: sample at negedge, update and drive after posedge
    always begin
        @(negedge clk);
        hs_ar = 1'b0;
        hs_r  = 1'b0;
        if (!rst_n) begin
            fifo_cnt = 0;
            rq.delete();
            exp_addr.delete();
            exp_len.delete();
            frame_active = 1'b0;
            hold_v = 1'b0;
        end else begin
            chk_eq("rready", bus.rready, !bus.fifo_wr_full);
            chk_eq("wr_en", bus.fifo_wr_en, bus.rvalid & !bus.fifo_wr_full);
            if (bus.arvalid && hold_v) begin
                chk_eq("ar_hold_addr", bus.araddr, hold_addr);
                chk_eq("ar_hold_len", bus.arlen, hold_len);
            end
            hold_v    = bus.arvalid && !bus.arready;
            hold_addr = bus.araddr;
            hold_len  = bus.arlen;
            hs_ar     = bus.arvalid && bus.arready;
            hs_r      = bus.fifo_wr_en && (rq.size() > 0);
            if (hs_ar) begin
                ar_cnt++;
                ar_len_hs = int'(bus.arlen);
                if (exp_addr.size() == 0) begin
                    chk_eq("ar_unexpected", 1, 0);
                end else begin
                    chk_eq("ar_addr", bus.araddr, exp_addr.pop_front());
                    chk_eq("ar_len", bus.arlen, exp_len.pop_front());
                end
            end
            if (bus.fifo_wr_en) begin
                wr_cnt++;
                chk_eq("fifo_no_ovf", fifo_cnt < FIFO_DEPTH, 1);
            end
            if (frame_done) begin
                done_cnt++;
                chk_eq("done_beats", wr_cnt, cur_beats);
                chk_eq("done_ar_left", exp_addr.size(), 0);
                frame_active = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            rd = rd_on && (fifo_cnt > 0) && ($urandom_range(0, 1) == 1);
            fifo_cnt = fifo_cnt + (hs_r ? 1 : 0) - (rd ? 1 : 0);
            if (hs_r) begin
                rq[0] = rq[0] - 1;
                if (rq[0] == 0) rq.pop_front();
            end
            if (hs_ar) rq.push_back(ar_len_hs + 1);
            case (ar_mode)
                0:       arready_v = ($urandom_range(0, 1) == 1);
                1:       arready_v = 1'b1;
                default: arready_v = 1'b0;
            endcase
            if (!(rvalid_v && !hs_r)) begin
                rvalid_v = (rq.size() > 0) && ($urandom_range(0, 3) != 0);
            end
            rlast_v = rvalid_v && (rq[0] == 1);
        end else begin
            arready_v = 1'b0;
            rvalid_v  = 1'b0;
            rlast_v   = 1'b0;
        end
    end

    task automatic start_frame(input logic [ADDR_W-1:0] base, input int beats);
        int                rem;
        int                b;
        logic [ADDR_W-1:0] a;
        @(posedge clk);
        #1;
        if (!frame_active) begin
            rem = beats;
            a   = base;
            while (rem > 0) begin
                b = (rem < BURST_LEN) ? rem : BURST_LEN;
                exp_addr.push_back(a);
                exp_len.push_back(b - 1);
                a   = a + ADDR_W'(b * BEAT_BYTES);
                rem = rem - b;
            end
            frame_active = 1'b1;
            wr_cnt       = 0;
            cur_beats    = beats;
        end
        frame_base  = base;
        frame_beats = BEATS_W'(beats);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk_eq(tag, done_cnt != d0, 1);
    endtask

    task automatic first_ar_latency(input string tag);
        int n;
        n = 1;
        while (!bus.arvalid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq(tag, n, 2);
    endtask

    task automatic wait_fifo_empty();
        int n;
        n = 0;
        while (fifo_cnt != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk_eq("fifo_empty", fifo_cnt, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0;
        int d0;
        int n;
        int seen;
        logic [ADDR_W-1:0] base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", frame_done, 0);
        chk_eq("rst_arvalid", bus.arvalid, 0);
        chk_eq("rst_araddr", bus.araddr, 0);
        chk_eq("rst_arlen", bus.arlen, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 64 beats from 0x100000, arready always high
        ar_mode = 1;
        rd_on   = 1'b1;
        a0 = ar_cnt;
        d0 = done_cnt;
        start_frame(28'h0100000, 64);
        first_ar_latency("t1_first_ar_lat");
        chk_eq("t1_busy", busy, 1);
        wait_done("t1_done", 2000);
        repeat (10) @(posedge clk);
        #1;
        chk_eq("t1_bursts", ar_cnt - a0, 4);
        chk_eq("t1_one_done", done_cnt - d0, 1);
        chk_eq("t1_idle", busy, 0);

        // 40 beats: 15, 15, 7
        a0 = ar_cnt;
        start_frame(28'h0234560, 40);
        wait_done("t2_done", 2000);
        chk_eq("t2_bursts", ar_cnt - a0, 3);

        // Water level held at 500, then 496
        wait_fifo_empty();
        lvl_ovr_en = 1'b1;
        lvl_ovr    = 500;
        a0 = ar_cnt;
        start_frame(28'h0400000, 64);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.arvalid) seen++;
        end
        chk_eq("t3_no_ar_at_500", seen, 0);
        lvl_ovr = 496;
        n = 0;
        while (!bus.arvalid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("t3_ar_at_496", n <= 2, 1);
        lvl_ovr_en = 1'b0;
        wait_done("t3_done", 3000);
        chk_eq("t3_bursts", ar_cnt - a0, 4);

        // Never read: 1024 beats stall at a full FIFO
        wait_fifo_empty();
        rd_on = 1'b0;
        a0 = ar_cnt;
        d0 = done_cnt;
        start_frame(28'h0800000, 1024);
        n = 0;
        while (fifo_cnt < FIFO_DEPTH && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (40) @(posedge clk);
        #1;
        chk_eq("t4_fifo_full", fifo_cnt, FIFO_DEPTH);
        chk_eq("t4_bursts_stop", ar_cnt - a0, FIFO_DEPTH / BURST_LEN);
        chk_eq("t4_no_arvalid", bus.arvalid, 0);
        chk_eq("t4_still_busy", busy, 1);
        chk_eq("t4_no_done", done_cnt - d0, 0);
        rd_on = 1'b1;
        wait_done("t4_done", 10000);
        chk_eq("t4_bursts_total", ar_cnt - a0, 1024 / BURST_LEN);

        // arready held low, ignored frame_start, zero-length frame
        ar_mode = 2;
        a0 = ar_cnt;
        d0 = done_cnt;
        start_frame(28'h0A00020, 32);
        n = 0;
        while (!bus.arvalid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("t5_arvalid", bus.arvalid, 1);
        repeat (4) @(posedge clk);
        #1;
        frame_base  = 28'h0C00000;
        frame_beats = BEATS_W'(5);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_eq("t5_held_addr", bus.araddr, 28'h0A00020);
        chk_eq("t5_held_len", bus.arlen, 15);
        ar_mode = 1;
        wait_done("t5_done", 2000);
        repeat (30) @(posedge clk);
        #1;
        chk_eq("t5_bursts", ar_cnt - a0, 2);
        chk_eq("t5_ignored_start", done_cnt - d0, 1);
        a0 = ar_cnt;
        d0 = done_cnt;
        start_frame(28'h0E00000, 0);
        n = 1;
        while (!frame_done && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("t5_zero_done_lat", n <= 2, 1);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("t5_zero_one_done", done_cnt - d0, 1);
        chk_eq("t5_zero_no_ar", ar_cnt - a0, 0);

        // Random frames with random arready
        ar_mode = 0;
        for (int i = 0; i < 6; i++) begin
            base = ADDR_W'($urandom());
            base[4:0] = '0;
            start_frame(base, $urandom_range(1, 120));
            wait_done("rand_done", 5000);
        end

        // Reset mid-burst, then a clean frame
        ar_mode = 1;
        wait_fifo_empty();
        start_frame(28'h0300000, 64);
        n = 0;
        while (ar_cnt < a0 + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        a0 = ar_cnt;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_done", frame_done, 0);
        chk_eq("t6_arvalid", bus.arvalid, 0);
        chk_eq("t6_araddr", bus.araddr, 0);
        chk_eq("t6_arlen", bus.arlen, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        a0 = ar_cnt;
        start_frame(28'h0500000, 48);
        first_ar_latency("t6_first_ar_lat");
        wait_done("t6_done_after_rst", 2000);
        chk_eq("t6_bursts", ar_cnt - a0, 3);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
